// File: rtl/recfn_to_int_pkg.sv
// Shared constants and types for the recoded-single to 64-bit integer converter.
package recfn_to_int_pkg;

  localparam logic [2:0] RmRne = 3'd0;
  localparam logic [2:0] RmRtz = 3'd1;
  localparam logic [2:0] RmRdn = 3'd2;
  localparam logic [2:0] RmRup = 3'd3;
  localparam logic [2:0] RmRmm = 3'd4;

  localparam int unsigned FlagInvalid  = 2;
  localparam int unsigned FlagOverflow = 1;
  localparam int unsigned FlagInexact  = 0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic [63:0] SatSignedMax   = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SatSignedMin   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SatUnsignedMax = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SatUnsignedMin = 64'h0000_0000_0000_0000;

endpackage

// File: rtl/recfn_to_int_core.sv
// Combinational decode, align, round and saturate of a recoded single to int64/uint64.
module recfn_to_int_core
  import recfn_to_int_pkg::*;
(
  input  logic [32:0] in_i,
  input  logic [2:0]  rm_i,
  input  logic        signed_out_i,
  output logic [63:0] out_o,
  output logic [2:0]  flags_o
);

  logic        sign;
  logic [8:0]  exp;
  logic [23:0] sig;
  logic        is_zero, is_special, is_nan, exp_big, tiny;
  logic [6:0]  shamt;
  logic [87:0] aligned;
  logic [63:0] int_part;
  logic        guard, sticky, round_up;
  logic [64:0] mag;
  logic        ovf_raw, invalid, overflow, inexact;

  always_comb begin
    sign       = in_i[32];
    exp        = in_i[31:23];
    sig        = {1'b1, in_i[22:0]};
    is_zero    = (exp[8:6] == 3'b000);
    is_special = (exp[8:7] == 2'b11);
    is_nan     = is_special & exp[6];
    exp_big    = (exp >= 9'd320);
    tiny       = (exp < 9'd255);
    // Shift so bit 24 is the units bit: 24 fraction bits give guard at [23], sticky below.
    shamt      = 7'(exp - 9'd255);
    aligned    = {64'd0, sig} << shamt;

    int_part = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    if (!is_zero) begin
      if (tiny) begin
        sticky = 1'b1;
      end else if (!exp_big) begin
        int_part = aligned[87:24];
        guard    = aligned[23];
        sticky   = |aligned[22:0];
      end
    end

    case (rm_i)
      RmRne:   round_up = guard & (sticky | int_part[0]);
      RmRdn:   round_up = sign & (guard | sticky);
      RmRup:   round_up = ~sign & (guard | sticky);
      RmRmm:   round_up = guard;
      default: round_up = 1'b0;
    endcase

    mag = {1'b0, int_part} + {64'd0, round_up};

    if (signed_out_i) begin
      ovf_raw = sign ? (mag > {2'b01, 63'd0}) : (mag[64:63] != 2'b00);
    end else begin
      ovf_raw = sign ? (mag != '0) : mag[64];
    end

    invalid  = ~is_zero & (is_special | exp_big);
    overflow = ovf_raw & ~invalid;
    inexact  = (guard | sticky) & ~invalid & ~overflow;

    flags_o               = '0;
    flags_o[FlagInvalid]  = invalid;
    flags_o[FlagOverflow] = overflow;
    flags_o[FlagInexact]  = inexact;

    if (invalid || overflow) begin
      if (is_nan || !sign) begin
        out_o = signed_out_i ? SatSignedMax : SatUnsignedMax;
      end else begin
        out_o = signed_out_i ? SatSignedMin : SatUnsignedMin;
      end
    end else if (signed_out_i && sign) begin
      out_o = -mag[63:0];
    end else begin
      out_o = mag[63:0];
    end
  end

endmodule

// File: rtl/recfn_to_int_seq.sv
// Three-state request/response wrapper around recfn_to_int_core.
// Optional sticky flag accumulator enabled by RECFN_TO_INT_STICKY_FLAGS_EN.
module recfn_to_int_seq
  import recfn_to_int_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [32:0] io_req_in,
  input  logic [2:0]  io_req_roundingMode,
  input  logic        io_req_signedOut,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [63:0] io_resp_out,
  output logic [2:0]  io_resp_intExceptionFlags
`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
  ,
  output logic [2:0]  io_flagsAccum,
  input  logic        io_flagsClear
`endif
);

  state_e      state_q, state_d;
  logic [32:0] in_q, in_d;
  logic [2:0]  rm_q, rm_d;
  logic        signed_q, signed_d;
  logic [63:0] out_q, out_d;
  logic [2:0]  flags_q, flags_d;
  logic [63:0] core_out;
  logic [2:0]  core_flags;

  recfn_to_int_core u_core (
    .in_i         (in_q),
    .rm_i         (rm_q),
    .signed_out_i (signed_q),
    .out_o        (core_out),
    .flags_o      (core_flags)
  );

  always_comb begin
    state_d  = state_q;
    in_d     = in_q;
    rm_d     = rm_q;
    signed_d = signed_q;
    out_d    = out_q;
    flags_d  = flags_q;
    case (state_q)
      StIdle: begin
        if (io_req_valid) begin
          in_d     = io_req_in;
          rm_d     = io_req_roundingMode;
          signed_d = io_req_signedOut;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        out_d   = core_out;
        flags_d = core_flags;
        state_d = StResp;
      end
      StResp: begin
        if (io_resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    io_req_ready              = (state_q == StIdle);
    io_resp_valid             = (state_q == StResp);
    io_resp_out               = out_q;
    io_resp_intExceptionFlags = flags_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      in_q     <= '0;
      rm_q     <= '0;
      signed_q <= 1'b0;
      out_q    <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      in_q     <= in_d;
      rm_q     <= rm_d;
      signed_q <= signed_d;
      out_q    <= out_d;
      flags_q  <= flags_d;
    end
  end

`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
  logic [2:0] accum_q, accum_d;

  always_comb begin
    accum_d = accum_q;
    if (state_q == StResp && io_resp_ready) accum_d = accum_q | flags_q;
    // A clear in the same cycle as a handshake drops that response's flags.
    if (io_flagsClear) accum_d = '0;
    io_flagsAccum = accum_q;
  end

  always_ff @(posedge clock) begin
    if (reset) accum_q <= '0;
    else       accum_q <= accum_d;
  end
`endif

endmodule

// File: tb/tb_recfn_to_int_seq.sv
// Bench for recfn_to_int_seq: directed table, stall/reset sequences and random vs. a reference model.
module tb_recfn_to_int_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_req_valid;
  logic        io_req_ready;
  logic [32:0] io_req_in;
  logic [2:0]  io_req_roundingMode;
  logic        io_req_signedOut;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [63:0] io_resp_out;
  logic [2:0]  io_resp_intExceptionFlags;
`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
  logic [2:0]  io_flagsAccum;
  logic        io_flagsClear;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  recfn_to_int_seq dut (
    .clock                     (clock),
    .reset                     (reset),
    .io_req_valid              (io_req_valid),
    .io_req_ready              (io_req_ready),
    .io_req_in                 (io_req_in),
    .io_req_roundingMode       (io_req_roundingMode),
    .io_req_signedOut          (io_req_signedOut),
    .io_resp_valid             (io_resp_valid),
    .io_resp_ready             (io_resp_ready),
    .io_resp_out               (io_resp_out),
    .io_resp_intExceptionFlags (io_resp_intExceptionFlags)
`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
    ,
    .io_flagsAccum             (io_flagsAccum),
    .io_flagsClear             (io_flagsClear)
`endif
  );

  typedef struct {
    logic [32:0] a;
    logic [2:0]  rm;
    logic        so;
    logic [63:0] out;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Exact rational reference: integer part, remainder vs. half, signed range test.
  function automatic void model(input logic [32:0] a, input logic [2:0] rm, input logic so,
                                output logic [63:0] o, output logic [2:0] f);
    logic                sgn;
    logic [8:0]          ex;
    int                  e;
    logic [127:0]        sig, ip, r, half;
    logic                up, invalid, ovf, nan;
    logic signed [129:0] mag, res, lo, hi;
    sgn = a[32];
    ex  = a[31:23];
    e   = int'(ex) - 256;
    nan = (ex[8:6] == 3'b111);
    o   = '0;
    f   = '0;
    if (ex[8:6] == 3'b000) return;
    invalid = (ex[8:7] == 2'b11) || (e >= 64);
    ovf     = 1'b0;
    r       = '0;
    half    = 128'd1;
    ip      = '0;
    if (!invalid) begin
      sig = {104'd0, 1'b1, a[22:0]};
      if (e >= 23) begin
        ip = sig << (e - 23);
      end else if (e >= -1) begin
        ip   = sig >> (23 - e);
        r    = sig & ((128'd1 << (23 - e)) - 128'd1);
        half = 128'd1 << (22 - e);
      end else begin
        r    = 128'd1;
        half = 128'd2;
      end
      case (rm)
        3'd0:    up = (r > half) || ((r == half) && ip[0]);
        3'd2:    up = sgn && (r != 0);
        3'd3:    up = !sgn && (r != 0);
        3'd4:    up = (r >= half);
        default: up = 1'b0;
      endcase
      mag = {2'b00, ip} + 130'(up);
      res = sgn ? -mag : mag;
      if (so) begin
        lo = -(130'sd1 <<< 63);
        hi = (130'sd1 <<< 63) - 130'sd1;
      end else begin
        lo = 130'sd0;
        hi = (130'sd1 <<< 64) - 130'sd1;
      end
      ovf = (res < lo) || (res > hi);
      if (!ovf) begin
        o = res[63:0];
        f = {2'b00, r != 0};
        return;
      end
    end
    f = invalid ? 3'b100 : 3'b010;
    if (nan || !sgn) o = so ? 64'h7FFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    else             o = so ? 64'h8000_0000_0000_0000 : 64'h0;
  endfunction

  task automatic send(input logic [32:0] a, input logic [2:0] rm, input logic so);
    int n;
    @(negedge clock);
    n = 0;
    while (!io_req_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    io_req_valid        = 1'b1;
    io_req_in           = a;
    io_req_roundingMode = rm;
    io_req_signedOut    = so;
    @(posedge clock);
    #1 io_req_valid = 1'b0;
  endtask

  // Returns cycles from the accepting cycle to the first cycle with io_resp_valid.
  task automatic wait_resp(output int lat);
    lat = 1;
    while (!io_resp_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic take_resp();
    io_resp_ready = 1'b1;
    @(posedge clock);
    #1 io_resp_ready = 1'b0;
  endtask

  task automatic run_op(input logic [32:0] a, input logic [2:0] rm, input logic so,
                        output logic [63:0] o, output logic [2:0] f, output int lat);
    send(a, rm, so);
    wait_resp(lat);
    o = io_resp_out;
    f = io_resp_intExceptionFlags;
    take_resp();
  endtask

  initial begin
    logic [63:0] o, mo;
    logic [2:0]  f, mf;
    int          lat;
    logic [8:0]  ex;
    logic [22:0] fr;
    logic [32:0] a;

    reset               = 1'b1;
    io_req_valid        = 1'b0;
    io_req_in           = '0;
    io_req_roundingMode = '0;
    io_req_signedOut    = 1'b0;
    io_resp_ready       = 1'b0;
`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
    io_flagsClear       = 1'b0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 64'(io_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(io_resp_valid), 64'd0);
    chk("rst_out", io_resp_out, 64'd0);
    chk("rst_flags", 64'(io_resp_intExceptionFlags), 64'd0);
`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
    chk("rst_accum", 64'(io_flagsAccum), 64'd0);
`endif
    reset = 1'b0;

    vecs.push_back('{a: 33'h080000000, rm: 3'd0, so: 1'b1, out: 64'd1, flags: 3'b000});
    vecs.push_back('{a: 33'h080A00000, rm: 3'd0, so: 1'b1, out: 64'd2, flags: 3'b001});
    vecs.push_back('{a: 33'h080A00000, rm: 3'd3, so: 1'b1, out: 64'd3, flags: 3'b001});
    vecs.push_back('{a: 33'h080A00000, rm: 3'd4, so: 1'b1, out: 64'd3, flags: 3'b001});
    vecs.push_back('{a: 33'h180000000, rm: 3'd0, so: 1'b1, out: 64'hFFFF_FFFF_FFFF_FFFF,
                     flags: 3'b000});
    vecs.push_back('{a: 33'h180000000, rm: 3'd0, so: 1'b0, out: 64'd0, flags: 3'b010});
    vecs.push_back('{a: 33'h0A0000000, rm: 3'd0, so: 1'b1, out: 64'h7FFF_FFFF_FFFF_FFFF,
                     flags: 3'b100});
    vecs.push_back('{a: 33'h0E0000000, rm: 3'd0, so: 1'b0, out: 64'hFFFF_FFFF_FFFF_FFFF,
                     flags: 3'b100});
    vecs.push_back('{a: {1'b1, 9'd319, 23'd0}, rm: 3'd1, so: 1'b1,
                     out: 64'h8000_0000_0000_0000, flags: 3'b000});
    vecs.push_back('{a: {1'b0, 9'd319, 23'd0}, rm: 3'd1, so: 1'b1,
                     out: 64'h7FFF_FFFF_FFFF_FFFF, flags: 3'b010});
    vecs.push_back('{a: {1'b0, 9'd319, 23'd0}, rm: 3'd1, so: 1'b0,
                     out: 64'h8000_0000_0000_0000, flags: 3'b000});
    vecs.push_back('{a: {1'b0, 9'd254, 23'd0}, rm: 3'd0, so: 1'b1, out: 64'd0, flags: 3'b001});
    vecs.push_back('{a: 33'h0, rm: 3'd0, so: 1'b1, out: 64'd0, flags: 3'b000});
    vecs.push_back('{a: {1'b1, 9'd255, 23'd0}, rm: 3'd2, so: 1'b1,
                     out: 64'hFFFF_FFFF_FFFF_FFFF, flags: 3'b001});
    vecs.push_back('{a: {1'b0, 9'd255, 23'd0}, rm: 3'd0, so: 1'b1, out: 64'd0, flags: 3'b001});
    vecs.push_back('{a: {1'b0, 9'd255, 23'd0}, rm: 3'd4, so: 1'b1, out: 64'd1, flags: 3'b001});
    vecs.push_back('{a: {1'b0, 9'd319, 23'h7FFFFF}, rm: 3'd1, so: 1'b0,
                     out: 64'hFFFF_FF00_0000_0000, flags: 3'b000});
    vecs.push_back('{a: {1'b1, 9'b110000000, 23'd0}, rm: 3'd0, so: 1'b1,
                     out: 64'h8000_0000_0000_0000, flags: 3'b100});
    vecs.push_back('{a: {1'b0, 9'd256, 23'h400000}, rm: 3'd0, so: 1'b1, out: 64'd2,
                     flags: 3'b001});
    vecs.push_back('{a: {1'b0, 9'd256, 23'h400000}, rm: 3'd6, so: 1'b1, out: 64'd1,
                     flags: 3'b001});
    vecs.push_back('{a: {1'b1, 9'd254, 23'd0}, rm: 3'd1, so: 1'b0, out: 64'd0, flags: 3'b001});
    vecs.push_back('{a: {1'b1, 9'd255, 23'h400000}, rm: 3'd0, so: 1'b0, out: 64'd0,
                     flags: 3'b010});

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].rm, vecs[i].so, o, f, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_out", i), o, vecs[i].out);
      chk($sformatf("vec%0d_flags", i), 64'(f), 64'(vecs[i].flags));
    end

    // Consumer stalls for five cycles: result must hold and no new request accepted.
    send(33'h080A00000, 3'd0, 1'b1);
    wait_resp(lat);
    chk("stall_latency", 64'(lat), 64'd2);
    io_req_valid = 1'b1;
    io_req_in    = 33'h080000000;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), 64'(io_resp_valid), 64'd1);
      chk($sformatf("stall%0d_ready", c), 64'(io_req_ready), 64'd0);
      chk($sformatf("stall%0d_out", c), io_resp_out, 64'd2);
      chk($sformatf("stall%0d_flags", c), 64'(io_resp_intExceptionFlags), 64'd1);
      @(posedge clock);
      #1;
    end
    io_req_valid = 1'b0;
    take_resp();
    chk("post_stall_idle", 64'(io_req_ready), 64'd1);

    // Reset while in CALC discards the operation.
    send(33'h080000000, 3'd0, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_calc_ready", 64'(io_req_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_calc_noresp%0d", c), 64'(io_resp_valid), 64'd0);
      @(posedge clock);
      #1;
    end
    run_op(33'h080A00000, 3'd3, 1'b1, o, f, lat);
    chk("recover_out", o, 64'd3);
    chk("recover_flags", 64'(f), 64'd1);

`ifdef RECFN_TO_INT_STICKY_FLAGS_EN
    @(negedge clock);
    io_flagsClear = 1'b1;
    @(negedge clock);
    io_flagsClear = 1'b0;
    chk("accum_cleared0", 64'(io_flagsAccum), 64'd0);
    run_op(33'h080A00000, 3'd0, 1'b1, o, f, lat);
    chk("accum_after1", 64'(io_flagsAccum), 64'd1);
    run_op(33'h0E0000000, 3'd0, 1'b0, o, f, lat);
    chk("accum_after2", 64'(io_flagsAccum), 64'd5);
    @(negedge clock);
    io_flagsClear = 1'b1;
    @(negedge clock);
    io_flagsClear = 1'b0;
    chk("accum_cleared1", 64'(io_flagsAccum), 64'd0);
`endif

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) ex = 9'($urandom_range(0, 511));
      else                           ex = 9'($urandom_range(240, 325));
      fr = 23'($urandom);
      if ($urandom_range(0, 1) == 1) fr = fr & (23'h7FFFFF << $urandom_range(0, 22));
      a = {1'($urandom), ex, fr};
      run_op(a, 3'($urandom_range(0, 7)), 1'($urandom), o, f, lat);
      model(io_req_in, io_req_roundingMode, io_req_signedOut, mo, mf);
      chk($sformatf("rnd%0d_lat in=%h", i, io_req_in), 64'(lat), 64'd2);
      chk($sformatf("rnd%0d_out in=%h rm=%0d s=%0d", i, io_req_in, io_req_roundingMode,
                    io_req_signedOut), o, mo);
      chk($sformatf("rnd%0d_flags in=%h rm=%0d s=%0d", i, io_req_in, io_req_roundingMode,
                    io_req_signedOut), 64'(f), 64'(mf));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recfn_to_int_seq.md
RECFN_TO_INT_SEQ -- requirements
Module: recfn_to_int_seq

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: io_req_valid  in  1  request present.
REQ-004 SHALL have ports: io_req_ready  out  1  block can accept a request.
REQ-005 SHALL have ports: io_req_in  in  33  recoded single {sign[32], exp[31:23] (9b), fract[22:0]}.
REQ-006 SHALL have ports: io_req_roundingMode  in  3  0=RNE, 1=RTZ, 2=RDN, 3=RUP, 4=RMM; 5..7 are treated as RTZ.
REQ-007 SHALL have ports: io_req_signedOut  in  1  1=int64 result, 0=uint64 result.
REQ-008 SHALL have ports: io_resp_valid  out  1  result held.
REQ-009 SHALL have ports: io_resp_ready  in  1  consumer takes result.
REQ-010 SHALL have ports: io_resp_out  out  64  integer result.
REQ-011 SHALL have ports: io_resp_intExceptionFlags  out  3  [2]=invalid, [1]=overflow, [0]=inexact.

Function
REQ-012 SHALL implement a three-state FSM: IDLE -> CALC -> RESP -> IDLE.
REQ-013 SHALL assert io_req_ready only in IDLE; a request is accepted on io_req_valid & io_req_ready, and its operands are registered.
REQ-014 SHALL spend exactly one cycle in CALC, then register the result and flags and enter RESP; io_resp_valid rises 2 cycles after acceptance.
REQ-015 SHALL hold io_resp_valid, io_resp_out and the flags stable in RESP until io_resp_ready=1, then return to IDLE; no new request is accepted in that same cycle (throughput is 1 per 3 cycles minimum).
REQ-016 SHALL decode the operand as: zero if exp[8:6]=000; special if exp[8:7]=11 (NaN if exp[6]=1, else Inf); otherwise value = (1.fract) * 2^(exp-256).
REQ-017 SHALL align the 24-bit significand into a 64-bit integer part plus guard and sticky bits, and round per the rounding mode: RNE ties to even; RMM ties away from zero; RDN/RUP use the sign.
REQ-018 SHALL set inexact when any discarded fraction bit is nonzero and the result is not invalid or overflow.
REQ-019 SHALL flag invalid for NaN or Inf, and for any unbiased exponent >= 64.
REQ-020 SHALL flag overflow when the rounded magnitude exceeds the destination range, including a negative nonzero rounded result with signedOut=0.
REQ-021 SHALL return the following on invalid or overflow: NaN or positive out-of-range gives 0x7FFF_FFFF_FFFF_FFFF when signed, 0xFFFF_FFFF_FFFF_FFFF when unsigned.
REQ-022 SHALL return the following on invalid or overflow: negative out-of-range gives 0x8000_0000_0000_0000 when signed, 0 when unsigned.
REQ-023 SHALL set exactly one of invalid and overflow when an exception occurs, giving invalid priority.
REQ-024 SHALL produce an exact -2^63 for signed output without overflow.
REQ-025 SHALL return 0 with no flags for ±0, and 0 with inexact for tiny values that round to zero.

Reset
REQ-026 SHALL, on reset, set the state to IDLE, io_req_ready=1, io_resp_valid=0, io_resp_out=0 and flags=0.
REQ-027 SHALL, on reset asserted in CALC or RESP, discard the in-flight result; no response is emitted.

Configuration
REQ-028 SHALL, with macro RECFN_TO_INT_STICKY_FLAGS_EN defined, add output io_flagsAccum (3 bits) and input io_flagsClear (1 bit).
REQ-029 SHALL, with the macro defined, OR io_flagsAccum with each response's flags on its RESP handshake; io_flagsClear zeroes it and wins over a same-cycle OR; reset value is 0.
REQ-030 SHALL, with the macro undefined, omit both ports and the register.

Structure
REQ-031 SHALL place rounding-mode constants, flag bit indices, the FSM state enum and the saturation constants in the shared package recfn_to_int_pkg.
REQ-032 SHALL implement decode, align, round and saturate as the combinational sub-module recfn_to_int_core, instantiated in the CALC stage.

Verification
REQ-033 SHALL cover: in=33'h080000000 (1.0), RNE, signed -> out=1, flags=000, io_resp_valid 2 cycles after accept.
REQ-034 SHALL cover: in=33'h080A00000 (2.5), RNE -> 2 with flags=001; RUP -> 3 with flags=001; RMM -> 3 with flags=001.
REQ-035 SHALL cover: in=33'h180000000 (-1.0) -> signed gives 0xFFFF_FFFF_FFFF_FFFF with flags=000; unsigned gives 0 with flags=010.
REQ-036 SHALL cover: in=33'h0A0000000 (2^64), signed -> 0x7FFF_FFFF_FFFF_FFFF, flags=100; in=33'h0E0000000 (NaN), unsigned -> 0xFFFF_FFFF_FFFF_FFFF, flags=100.
REQ-037 SHALL cover: io_resp_ready held low for 5 cycles -> outputs stable and io_req_ready=0 throughout; reset pulsed in CALC -> no response, IDLE the next cycle.
REQ-038 SHALL cover (macro defined): two responses with flags 001 and 100 -> io_flagsAccum=101; io_flagsClear pulse -> 000.
